// File: rtl/fib_regfile_engine_if.sv
// fib_regfile_engine_if: start/seed/inspection inputs and status outputs of fib_regfile_engine
interface fib_regfile_engine_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);
  logic             start;
  logic [WIDTH-1:0] seed0;
  logic [WIDTH-1:0] seed1;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             overflow;
  modport master (output start, seed0, seed1, raddr, input rdata, result, busy, done, overflow);
  modport slave (input start, seed0, seed1, raddr, output rdata, result, busy, done, overflow);
endinterface

// File: rtl/fib_regfile_engine.sv
// fib_regfile_engine: register file filled by a seeded additive sequence r[i]=r[i-1]+r[i-2].
// Define FIB_REGFILE_SATURATE_EN to store all-ones on overflow instead of wrapping.
module fib_regfile_engine #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input logic clk,
  input logic rst,
  fib_regfile_engine_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, INIT0, INIT1, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] s0, s1, wval;
  logic [AW-1:0] idx;
  logic [WIDTH:0] sum;
  assign sum = {1'b0, regs[idx - AW'(1)]} + {1'b0, regs[idx - AW'(2)]};
`ifdef FIB_REGFILE_SATURATE_EN
  assign wval = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
  assign wval = sum[WIDTH-1:0];
`endif
  // no write bypass: a same-cycle read sees the old contents
  assign bus.rdata = (int'(bus.raddr) < DEPTH) ? regs[bus.raddr] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      s0 <= '0;
      s1 <= '0;
      idx <= '0;
      bus.result <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          s0 <= bus.seed0;
          s1 <= bus.seed1;
          state <= INIT0;
          bus.busy <= 1'b1;
          bus.done <= 1'b0;
          bus.overflow <= 1'b0;
        end
        INIT0: begin
          regs[0] <= s0;
          bus.result <= s0;
          state <= INIT1;
        end
        INIT1: begin
          regs[1] <= s1;
          bus.result <= s1;
          idx <= AW'(2);
          state <= RUN;
        end
        RUN: begin
          regs[idx] <= wval;
          bus.result <= wval;
          idx <= idx + AW'(1);
          if (sum[WIDTH]) bus.overflow <= 1'b1;
          if (idx == AW'(DEPTH - 1)) begin
            state <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fib_regfile_engine.sv
// tb_fib_regfile_engine: directed and random runs of a 32x32 and an 8x20 engine against a sequence model
module tb_fib_regfile_engine;
  localparam int D0 = 32;
  localparam int D1 = 20;
`ifdef FIB_REGFILE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fib_regfile_engine_if #(.WIDTH(32), .DEPTH(D0)) b0 ();
  fib_regfile_engine_if #(.WIDTH(8), .DEPTH(D1)) b1 ();
  fib_regfile_engine #(.WIDTH(32), .DEPTH(D0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  fib_regfile_engine #(.WIDTH(8), .DEPTH(D1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  int pass_n = 0;
  int total_n = 0;
  longint seq [2][32];
  bit ovf_at [2][32];
  longint mreg [2][32];
  longint mres [2];
  bit mov [2];
  int n [2];
  function automatic int dep(int d);
    return d ? D1 : D0;
  endfunction
  function automatic longint msk(int d);
    return d ? 64'hFF : 64'hFFFF_FFFF;
  endfunction
  task automatic chk(string nm, longint act, longint exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) mreg[d][i] = 0;
      mres[d] = 0;
      mov[d] = 1'b0;
      n[d] = -1;
    end
  endtask
  // n counts edges since the accepted start; busy for n in 1..DEPTH, r[k] lands when n reaches k+2
  task automatic model_edge(int d, bit st, longint a, longint b);
    longint s;
    int k;
    if (n[d] >= 1 && n[d] <= dep(d)) begin
      n[d]++;
      k = n[d] - 2;
      if (k >= 0) begin
        mreg[d][k] = seq[d][k];
        mres[d] = seq[d][k];
        if (ovf_at[d][k]) mov[d] = 1'b1;
      end
    end else if (st) begin
      seq[d][0] = a & msk(d);
      seq[d][1] = b & msk(d);
      ovf_at[d][0] = 1'b0;
      ovf_at[d][1] = 1'b0;
      for (int i = 2; i < dep(d); i++) begin
        s = seq[d][i-1] + seq[d][i-2];
        ovf_at[d][i] = s > msk(d);
        seq[d][i] = ovf_at[d][i] ? (SAT ? msk(d) : (s & msk(d))) : s;
      end
      n[d] = 1;
      mov[d] = 1'b0;
    end
  endtask
  task automatic chk_dut(int d, bit bz, bit dn, bit ov, longint res, longint rd, int ra);
    chk($sformatf("dut%0d busy", d), longint'(bz), longint'(n[d] >= 1 && n[d] <= dep(d)));
    chk($sformatf("dut%0d done", d), longint'(dn), longint'(n[d] > dep(d)));
    chk($sformatf("dut%0d overflow", d), longint'(ov), longint'(mov[d]));
    chk($sformatf("dut%0d result", d), res, mres[d]);
    chk($sformatf("dut%0d rdata[%0d]", d, ra), rd, ra < dep(d) ? mreg[d][ra] : 0);
  endtask
  task automatic check_all();
    chk_dut(0, b0.busy, b0.done, b0.overflow, longint'(b0.result), longint'(b0.rdata), int'(b0.raddr));
    chk_dut(1, b1.busy, b1.done, b1.overflow, longint'(b1.result), longint'(b1.rdata), int'(b1.raddr));
  endtask
  task automatic step(bit st, longint a, longint b, int r0 = -1, int r1 = -1);
    @(negedge clk);
    b0.start = st;
    b1.start = st;
    b0.seed0 = 32'(a);
    b0.seed1 = 32'(b);
    b1.seed0 = 8'(a);
    b1.seed1 = 8'(b);
    b0.raddr = 5'(r0 < 0 ? int'($urandom_range(31)) : r0);
    b1.raddr = 5'(r1 < 0 ? int'($urandom_range(31)) : r1);
    @(posedge clk);
    if (!rst) begin
      model_edge(0, st, a, b);
      model_edge(1, st, a, b);
    end
    #1 check_all();
  endtask
  task automatic zero_outputs(string tag);
    chk({tag, " busy0"}, longint'(b0.busy), 0);
    chk({tag, " done0"}, longint'(b0.done), 0);
    chk({tag, " ovf0"}, longint'(b0.overflow), 0);
    chk({tag, " result0"}, longint'(b0.result), 0);
    chk({tag, " busy1"}, longint'(b1.busy), 0);
    chk({tag, " result1"}, longint'(b1.result), 0);
  endtask
  initial begin
    b0.start = 1'b0; b0.seed0 = '0; b0.seed1 = '0; b0.raddr = '0;
    b1.start = 1'b0; b1.seed0 = '0; b1.seed1 = '0; b1.raddr = '0;
    model_reset();
    step(0, 0, 0);
    step(0, 0, 0, 7, 7);
    zero_outputs("reset");
    #3 rst = 1'b0;
    // seeds 1/1: plain Fibonacci, 8-bit engine overflows at r[13]
    step(1, 1, 1);
    for (int i = 1; i <= 33; i++) begin
      step(0, 0, 0);
      if (i == 31) chk("busy at E31", longint'(b0.busy), 1);
      if (i == 32) chk("done at E32", longint'(b0.done), 1);
      if (i == 13) chk("ovf8 after r12", longint'(b1.overflow), 0);
      if (i == 14) chk("ovf8 after r13", longint'(b1.overflow), 1);
      if (i == 20) chk("done8 at E20", longint'(b1.done), 1);
    end
    chk("model r31", mreg[0][31], 2178309);
    chk("model r10", mreg[0][10], 89);
    step(0, 0, 0, 2, 12);
    chk("r2", longint'(b0.rdata), 2);
    chk("r12 w8", longint'(b1.rdata), 233);
    step(0, 0, 0, 10, 13);
    chk("r10", longint'(b0.rdata), 89);
    chk("r13 w8", longint'(b1.rdata), SAT ? 255 : 121);
    step(0, 0, 0, 31, 14);
    chk("r31", longint'(b0.rdata), 2178309);
    chk("r14 w8", longint'(b1.rdata), SAT ? 255 : 98);
    chk("result32", longint'(b0.result), 2178309);
    chk("ovf32", longint'(b0.overflow), 0);
    chk("ovf8 sticky", longint'(b1.overflow), 1);
    for (int a = 20; a < 32; a++) begin
      step(0, 0, 0, 0, a);
      chk($sformatf("w8 out of range %0d", a), longint'(b1.rdata), 0);
    end
    // restart attempt during a run is ignored
    step(1, 1, 1);
    for (int i = 1; i <= 33; i++) begin
      step(i == 5, 7, 9);
      if (i == 31) chk("rerun busy E31", longint'(b0.busy), 1);
      if (i == 32) chk("rerun done E32", longint'(b0.done), 1);
    end
    step(0, 0, 0, 10, 1);
    chk("rerun r10", longint'(b0.rdata), 89);
    // async reset mid-run clears everything at once
    step(1, longint'($urandom), longint'($urandom));
    for (int i = 1; i <= 10; i++) step(0, 0, 0);
    #3 rst = 1'b1;
    #1 zero_outputs("async reset");
    model_reset();
    check_all();
    for (int a = 0; a < 32; a++) begin
      step(0, 0, 0, a, a);
      if (a == 31) chk("reset r31", longint'(b0.rdata), 0);
    end
    #3 rst = 1'b0;
    step(1, 3, 4);
    for (int i = 1; i <= 33; i++) step(0, 0, 0);
    step(0, 0, 0, 2, 2);
    chk("seeds34 r2", longint'(b0.rdata), 7);
    chk("seeds34 r2 w8", longint'(b1.rdata), 7);
    // from DONE, zero seeds clear every entry
    step(1, 0, 0);
    for (int i = 1; i <= 33; i++) step(0, 0, 0);
    chk("zero result", longint'(b0.result), 0);
    for (int a = 0; a < 32; a++) step(0, 0, 0, a, a);
    chk("zero r31", longint'(b0.rdata), 0);
    // random seeds, stray starts during runs and restarts from DONE
    for (int r = 0; r < 6; r++) begin
      step(1, longint'($urandom), longint'($urandom));
      for (int i = 0; i < 34 + int'($urandom_range(3)); i++)
        step($urandom_range(7) == 0, longint'($urandom), longint'($urandom));
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
